// File: rtl/imem_fetch_server.sv
// rtl/imem_fetch_server.sv - round-robin shared IMEM fetch server for NUM_CORES fetch stages
module imem_fetch_server #(
    parameter int          NUM_CORES  = 4,
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CORES-1:0]      req_valid,
    input  logic [32*NUM_CORES-1:0]   req_pc,
    output logic [NUM_CORES-1:0]      req_ready,
    input  logic [NUM_CORES-1:0]      flush,
    output logic [NUM_CORES-1:0]      resp_valid,
    output logic [32*NUM_CORES-1:0]   resp_instr,
    output logic [NUM_CORES-1:0]      resp_fault,
    output logic                      mem_en,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [31:0]               mem_rdata
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [IDX_W-1:0]                ptr;
    logic [IDX_W-1:0]                gnt_idx;
    logic                            gnt_any;
    logic [31:0]                     gnt_pc;
    logic                            gnt_fault;

    logic                            if_valid;
    logic [IDX_W-1:0]                if_idx;
    logic                            if_fault;
    logic [31:0]                     deliver_instr;
    logic [NUM_CORES-1:0][31:0]      hold;

    // First requester at or after ptr wins; nothing is granted while in reset.
    always_comb begin
        int c;
        c         = 0;
        req_ready = '0;
        gnt_idx   = '0;
        gnt_any   = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            c = (int'(ptr) + i) % NUM_CORES;
            if (!gnt_any && rst && req_valid[c]) begin
                req_ready[c] = 1'b1;
                gnt_idx      = IDX_W'(c);
                gnt_any      = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_pc    = req_pc[32*int'(gnt_idx) +: 32];
        gnt_fault = (gnt_pc[1:0] != 2'b00) || (|gnt_pc[31:ADDR_WIDTH+2]);
        mem_en    = gnt_any && !gnt_fault;
        mem_addr  = mem_en ? gnt_pc[ADDR_WIDTH+1:2] : '0;
    end

    assign deliver_instr = if_fault ? NOP_INSTR : mem_rdata;

    always_comb begin
        resp_valid = '0;
        resp_fault = '0;
        resp_instr = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            resp_valid[k] = rst && if_valid && (if_idx == IDX_W'(k)) && !flush[k];
            resp_fault[k] = resp_valid[k] && if_fault;
            if (!rst)
                resp_instr[32*k +: 32] = NOP_INSTR;
            else if (resp_valid[k])
                resp_instr[32*k +: 32] = deliver_instr;
            else
                resp_instr[32*k +: 32] = hold[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr      <= '0;
            if_valid <= 1'b0;
            if_idx   <= '0;
            if_fault <= 1'b0;
            for (int k = 0; k < NUM_CORES; k++)
                hold[k] <= NOP_INSTR;
        end else begin
            if (gnt_any)
                ptr <= (gnt_idx == IDX_W'(NUM_CORES-1)) ? '0 : gnt_idx + 1'b1;
            if_valid <= gnt_any;
            if_idx   <= gnt_idx;
            if_fault <= gnt_any && gnt_fault;
            // Flushed responses leave the previously delivered instruction visible.
            for (int k = 0; k < NUM_CORES; k++)
                if (resp_valid[k])
                    hold[k] <= deliver_instr;
        end
    end

endmodule

// File: doc/imem_fetch_server.md
# imem_fetch_server

Shared instruction-memory front end for the multi-core processor: accepts fetch requests carrying a PC from NUM_CORES fetch stages, arbitrates round-robin onto one synchronous-read IMEM port, and returns each instruction on that core's instruction input one cycle after grant. It is the memory-side counterpart of each core's fetch stage, which holds the PC and consumes the returned instruction. Misaligned or out-of-range PCs are faulted locally and never reach the IMEM.

## Interface
- NUM_CORES, 4, number of requesting cores (2..8)
- ADDR_WIDTH, 10, IMEM word-address width; byte space is 2^(ADDR_WIDTH+2)
- NOP_INSTR, 32'h0000_0013, instruction returned on fault and at reset
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- req_valid  in  NUM_CORES  per-core fetch request
- req_pc  in  32*NUM_CORES  per-core byte PC, core k in bits [32k+31:32k]
- req_ready  out  NUM_CORES  one-hot grant, combinational, same cycle as request
- flush  in  NUM_CORES  per-core discard of an in-flight response
- resp_valid  out  NUM_CORES  one-cycle pulse, instruction for core k valid
- resp_instr  out  32*NUM_CORES  per-core instruction, holds last delivered value
- resp_fault  out  NUM_CORES  qualifies resp_valid: PC misaligned or out of range
- mem_en  out  1  IMEM read enable
- mem_addr  out  ADDR_WIDTH  IMEM word address
- mem_rdata  in  32  IMEM read data, valid the cycle after mem_en

## Operation
- Round-robin pointer ptr (0..NUM_CORES-1): grant the first core with req_valid=1 scanning ptr, ptr+1, ... modulo NUM_CORES.
- At most one grant per cycle; req_ready is one-hot or zero. Ungranted cores keep req_valid and req_pc stable until granted.
- On a grant to core k: ptr <= (k+1) mod NUM_CORES. With no requests, ptr is unchanged.
- Fault check on granted PC: fault if pc[1:0]!=0 or pc >= 2^(ADDR_WIDTH+2). No fault: mem_en=1, mem_addr=pc[ADDR_WIDTH+1:2]. Fault: mem_en=0, mem_addr=0.
- In-flight register: valid bit, core index, fault bit; loaded every cycle from the grant.
- Response cycle (cycle after grant to core k): resp_valid[k]=1 unless flush[k]=1 in that cycle; resp_fault[k]=fault bit; resp_instr[k]=mem_rdata (combinational pass-through), or NOP_INSTR on fault.
- Hold register per core captures the delivered instruction at the end of the response cycle; outside response cycles resp_instr[k] shows the hold register. A flushed response does not update the hold register.
- flush affects only the response cycle; flush on a core with no in-flight response is ignored. flush does not block a new grant to that core in the same cycle.

## Timing
- Reset (rst=0 at a clk edge): ptr=0, in-flight valid=0, all hold registers=NOP_INSTR. While rst=0: req_ready=0, mem_en=0, mem_addr=0, resp_valid=0, resp_fault=0, resp_instr[k]=NOP_INSTR.
- Reset mid-operation: in-flight request discarded; no response is produced in the cycle after rst returns to 1.
- Latency: grant in cycle T -> resp_valid in T+1. Throughput: one fetch per cycle aggregate; a lone requester is granted every cycle (back-to-back, pipelined).
- Core may be granted in T+1 while its T response is delivered; that new response arrives in T+2.
- resp_valid and resp_fault are low in every cycle except a response cycle for that core.

## Test plan
- Reset: rst=0 for 3 cycles with all req_valid=1 -> req_ready=0, mem_en=0, resp_instr all 0x00000013; first cycle after release grants core 0.
- Single core: core 2 requests pc=0x40 continuously, IMEM word 0x10=0xDEADBEEF -> mem_addr=0x10 each cycle, resp_valid[2] every cycle from the second, resp_instr[2]=0xDEADBEEF.
- Round-robin: all 4 cores request every cycle -> grants 0,1,2,3,0,... each one-hot; responses follow in the same order, one cycle later.
- Faults: core 1 pc=0x42 and later pc=0x1000 (ADDR_WIDTH=10) -> mem_en=0; resp_valid[1]=1, resp_fault[1]=1, resp_instr[1]=0x00000013.
- Flush: core 3 granted pc=0x8 (word=0x12345678), flush[3]=1 next cycle -> resp_valid[3]=0, resp_instr[3] keeps the prior value.
- Mid-flight reset: grant core 0, assert rst=0 the next cycle -> resp_valid stays 0, hold register returns to 0x00000013, ptr=0.
